// File: rtl/alu_ctrl.sv
// alu_ctrl: multi-cycle fetch/execute controller that drives an external combinational ALU.
// Define ALU_CTRL_WATCHDOG_EN to add the fetch-timeout watchdog that raises err.
module alu_ctrl #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] instr_addr,
   output logic            instr_req,
   input  logic            instr_ack,
   input  logic [15:0]     instr_data,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic [2:0]      alu_op,
   input  logic [7:0]      alu_y,
   input  logic            alu_zero,
   output logic            busy,
   output logic            halted,
   output logic            err,
   input  logic [1:0]      dbg_sel,
   output logic [7:0]      dbg_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t          state_reg;
   logic [PC_W-1:0] pc_reg;
   logic [15:0]     ir_reg;
   logic            z_reg;
   logic            req_reg;
   logic            busy_reg;
   logic            halted_reg;
   logic [7:0]      rf [4];

   logic            wr_en;
   logic [1:0]      wr_sel;
   logic [7:0]      wr_val;
   logic            jmp_taken;

`ifdef ALU_CTRL_WATCHDOG_EN
   logic            err_reg;
   logic [3:0]      wd_reg;
`endif

   // ALU and LDI both write back; they differ only in where rd and the data come from.
   assign wr_en     = (state_reg == EXEC) && !ir_reg[15];
   assign wr_sel    = ir_reg[14] ? ir_reg[13:12] : ir_reg[10:9];
   assign wr_val    = ir_reg[14] ? ir_reg[7:0]   : alu_y;
   assign jmp_taken = !ir_reg[13] || z_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rf
         logic [7:0] q_reg;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               q_reg <= '0;
            end else if (wr_en && (wr_sel == 2'(gi))) begin
               q_reg <= wr_val;
            end
         end
         assign rf[gi] = q_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         pc_reg     <= '0;
         ir_reg     <= '0;
         z_reg      <= 1'b0;
         req_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         halted_reg <= 1'b0;
`ifdef ALU_CTRL_WATCHDOG_EN
         err_reg    <= 1'b0;
         wd_reg     <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE, HALT: begin
               if (start) begin
                  state_reg  <= FETCH;
                  pc_reg     <= '0;
                  req_reg    <= 1'b1;
                  busy_reg   <= 1'b1;
                  halted_reg <= 1'b0;
`ifdef ALU_CTRL_WATCHDOG_EN
                  err_reg    <= 1'b0;
                  wd_reg     <= '0;
`endif
               end
            end
            FETCH: begin
               if (instr_ack) begin
                  state_reg <= EXEC;
                  ir_reg    <= instr_data;
                  pc_reg    <= pc_reg + PC_W'(1);
                  req_reg   <= 1'b0;
               end
`ifdef ALU_CTRL_WATCHDOG_EN
               // wd_reg counts ack-less cycles already spent; this is the 15th.
               else if (wd_reg == 4'd14) begin
                  state_reg  <= HALT;
                  req_reg    <= 1'b0;
                  busy_reg   <= 1'b0;
                  halted_reg <= 1'b1;
                  err_reg    <= 1'b1;
               end else begin
                  wd_reg <= wd_reg + 4'd1;
               end
`endif
            end
            EXEC: begin
               if (ir_reg[15:14] == 2'b11) begin
                  state_reg  <= HALT;
                  busy_reg   <= 1'b0;
                  halted_reg <= 1'b1;
               end else begin
                  state_reg <= FETCH;
                  req_reg   <= 1'b1;
`ifdef ALU_CTRL_WATCHDOG_EN
                  wd_reg    <= '0;
`endif
               end
               if (ir_reg[15:14] == 2'b00) begin
                  z_reg <= alu_zero;
               end
               if ((ir_reg[15:14] == 2'b10) && jmp_taken) begin
                  pc_reg <= ir_reg[PC_W-1:0];
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign instr_addr = pc_reg;
   assign instr_req  = req_reg;
   assign busy       = busy_reg;
   assign halted     = halted_reg;
   assign alu_a      = rf[ir_reg[8:7]];
   assign alu_b      = rf[ir_reg[6:5]];
   assign alu_op     = ir_reg[13:11];
   assign dbg_data   = rf[dbg_sel];

`ifdef ALU_CTRL_WATCHDOG_EN
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: instruction-level model checked every cycle plus directed program runs.
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  instr_addr;
   logic        instr_req;
   logic        instr_ack = 1'b0;
   logic [15:0] instr_data = 16'h0000;
   logic [7:0]  alu_a, alu_b, alu_y;
   logic [2:0]  alu_op;
   logic        alu_zero;
   logic        busy, halted, err;
   logic [1:0]  dbg_sel = 2'd0;
   logic [7:0]  dbg_data;

   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] rom [256];
   int          rom_wait = 0;
   logic        rom_noack = 1'b0;
   logic        ack_noise = 1'b0;

   // model state: architectural registers plus which phase is expected next cycle
   logic [7:0]  m_r [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
   logic        m_z = 1'b0;
   logic [7:0]  m_pc = 8'h0;
   logic [15:0] m_ir = 16'h0;
   logic        m_fetch = 1'b0, m_exec = 1'b0, m_halt = 1'b0, m_err = 1'b0;
   int          wait_cnt = 0;
   int          req_run = 0;
   logic [7:0]  q_addr [$];
   int          q_len [$];

   always #5 clk = ~clk;

   alu_ctrl #(.PC_W(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack),
      .instr_data(instr_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_y(alu_y), .alu_zero(alu_zero), .busy(busy), .halted(halted),
      .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a;
         default: return b;
      endcase
   endfunction

   assign alu_y    = alu_f(alu_op, alu_a, alu_b);
   assign alu_zero = (alu_y == 8'h00);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare and model advance; also plays the ROM
   always @(negedge clk) begin
      if (instr_req) req_run++;
      else if (req_run != 0) begin
         q_len.push_back(req_run);
         req_run = 0;
      end
      if (!reset) begin
         for (int i = 0; i < 4; i++) m_r[i] = 8'h0;
         m_z = 0; m_pc = 0; m_ir = 0; m_fetch = 0; m_exec = 0; m_halt = 0; m_err = 0;
         instr_ack = 0;
         chk("rst_req", instr_req, 0);
         chk("rst_busy", busy, 0);
         chk("rst_halted", halted, 0);
         chk("rst_err", err, 0);
         chk("rst_addr", instr_addr, 0);
         chk("rst_op", alu_op, 0);
         chk("rst_a", alu_a, 0);
         chk("rst_b", alu_b, 0);
         chk("rst_dbg", dbg_data, 0);
      end else begin
         chk("busy", busy, m_fetch || m_exec);
         chk("halted", halted, m_halt);
         chk("req", instr_req, m_fetch);
         chk("err", err, m_err);
         chk("dbg", dbg_data, m_r[dbg_sel]);
         if (m_fetch) chk("addr", instr_addr, m_pc);
         if (m_exec) begin
            chk("alu_a", alu_a, m_r[m_ir[8:7]]);
            chk("alu_b", alu_b, m_r[m_ir[6:5]]);
            chk("alu_op", alu_op, m_ir[13:11]);
         end
         if (m_exec) begin
            instr_ack  = ack_noise;
            instr_data = 16'hC000;
            case (m_ir[15:14])
               2'b00: begin
                  logic [7:0] y;
                  y = alu_f(m_ir[13:11], m_r[m_ir[8:7]], m_r[m_ir[6:5]]);
                  m_r[m_ir[10:9]] = y;
                  m_z = (y == 8'h00);
               end
               2'b01: m_r[m_ir[13:12]] = m_ir[7:0];
               2'b10: if (!m_ir[13] || m_z) m_pc = m_ir[7:0];
               default: m_halt = 1;
            endcase
            m_exec = 0;
            m_fetch = !m_halt;
            wait_cnt = 0;
         end else if (m_fetch) begin
            if (!rom_noack && wait_cnt >= rom_wait) begin
               instr_ack  = 1;
               instr_data = rom[m_pc];
               m_ir = rom[m_pc];
               q_addr.push_back(instr_addr);
               m_pc = m_pc + 8'd1;
               m_fetch = 0;
               m_exec = 1;
            end else begin
               instr_ack = 0;
               wait_cnt++;
`ifdef ALU_CTRL_WATCHDOG_EN
               if (wait_cnt == 15) begin
                  m_fetch = 0; m_halt = 1; m_err = 1;
               end
`endif
            end
         end else begin
            instr_ack  = ack_noise;
            instr_data = 16'hC000;
            if (start) begin
               m_pc = 0; m_fetch = 1; m_halt = 0; m_err = 0; wait_cnt = 0;
            end
         end
      end
   end

   task automatic load_halts();
      for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
   endtask

   task automatic pulse_start();
      q_addr.delete();
      q_len.delete();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask

   task automatic run_prog(input string name, output int cyc);
      pulse_start();
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!halted && cyc < 300);
      chk({name, "_done"}, halted, 1);
      $display("run %s: %0d cycles, %0d fetches", name, cyc, q_addr.size());
   endtask

   task automatic rd(input string name, input logic [1:0] sel, input logic [7:0] exp);
      dbg_sel = sel;
      #1 chk(name, dbg_data, exp);
   endtask

   task automatic seq(input string name, input int idx, input logic [7:0] exp);
      if (idx < q_addr.size()) chk(name, q_addr[idx], exp);
      else chk({name, "_missing"}, q_addr.size(), idx + 1);
   endtask

   int  cyc;
   logic found;

   initial begin
      load_halts();
      repeat (3) @(posedge clk);
      #1 chk("rst_busy_l", busy, 0);
      chk("rst_req_l", instr_req, 0);
      reset = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) rd("rst_reg", 2'(i), 8'h00);

      // add 5+3 into r3
      load_halts();
      rom[0] = 16'h5005; rom[1] = 16'h6003; rom[2] = 16'h16C0; rom[3] = 16'hC000;
      run_prog("add", cyc);
      chk("add_cycles", cyc, 8);
      chk("add_nfetch", q_addr.size(), 4);
      for (int i = 0; i < 4; i++) seq("add_seq", i, 8'(i));
      rd("add_r3", 2'd3, 8'h08);
      rd("add_r1", 2'd1, 8'h05);

      // r0 = r1-r1 sets Z, conditional jump taken; ack noise outside FETCH
      ack_noise = 1;
      load_halts();
      rom[0] = 16'h5007; rom[1] = 16'h18A0; rom[2] = 16'hA010;
      run_prog("jmp_taken", cyc);
      seq("jt_target", 3, 8'h10);
      rd("jt_r0", 2'd0, 8'h00);
      // r0 = r1-r2 = 4, jump falls through
      rom[1] = 16'h18C0;
      run_prog("jmp_not", cyc);
      seq("jn_next", 3, 8'h03);
      rd("jn_r0", 2'd0, 8'h04);
      ack_noise = 0;

      // FF+01 wraps to 0, Z survives an LDI
      load_halts();
      rom[0] = 16'h50FF; rom[1] = 16'h6001; rom[2] = 16'h16C0; rom[3] = 16'h4055;
      rom[4] = 16'hA030;
      run_prog("wrap", cyc);
      seq("wrap_jmp", 5, 8'h30);
      rd("wrap_r3", 2'd3, 8'h00);
      rd("wrap_r0", 2'd0, 8'h55);

      // PC wraps from 0xFF to 0
      load_halts();
      rom[0] = 16'hA0FF; rom[255] = 16'h1EC0;
      run_prog("pcwrap", cyc);
      seq("pcw_ff", 1, 8'hFF);
      seq("pcw_zero", 2, 8'h00);
      seq("pcw_one", 3, 8'h01);
      rd("pcw_r3", 2'd3, 8'hFE);

      // three-cycle ack delay
      rom_wait = 3;
      load_halts();
      rom[0] = 16'h4021;
      run_prog("slow", cyc);
      chk("slow_cycles", cyc, 10);
      if (q_len.size() > 0) chk("slow_reqlen", q_len[0], 4);
      else chk("slow_reqlen_missing", q_len.size(), 1);
      rd("slow_r0", 2'd0, 8'h21);
      rom_wait = 0;

      // ack withheld
      rom_noack = 1;
`ifdef ALU_CTRL_WATCHDOG_EN
      run_prog("watchdog", cyc);
      chk("wd_cycles", cyc, 15);
      chk("wd_err", err, 1);
      rom_noack = 0;
`else
      pulse_start();
      repeat (20) @(posedge clk);
      #1 chk("nowd_req", instr_req, 1);
      chk("nowd_err", err, 0);
      chk("nowd_halted", halted, 0);
      $display("run nowatchdog: fetch still pending after 20 cycles");
      rom_noack = 0;
      reset = 0;
      @(posedge clk); #1 reset = 1;
`endif

      // reset during EXEC of an ALU write
      load_halts();
      rom[0] = 16'h5011; rom[1] = 16'h6022; rom[2] = 16'h16C0; rom[3] = 16'hC000;
      pulse_start();
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (busy && !instr_req && alu_op == 3'd2 && instr_addr == 8'd3) found = 1;
      end
      chk("rst_exec_found", found, 1);
      #2 reset = 0;
      repeat (2) @(posedge clk);
      #1 chk("mid_req", instr_req, 0);
      chk("mid_busy", busy, 0);
      chk("mid_halted", halted, 0);
      chk("mid_err", err, 0);
      chk("mid_addr", instr_addr, 0);
      chk("mid_op", alu_op, 0);
      chk("mid_a", alu_a, 0);
      rd("mid_r3", 2'd3, 8'h00);
      reset = 1;
      $display("run midreset: reset applied during ALU EXEC");
      load_halts();
      rom[0] = 16'h5005; rom[1] = 16'h6003; rom[2] = 16'h16C0; rom[3] = 16'hC000;
      run_prog("after_reset", cyc);
      chk("ar_cycles", cyc, 8);
      seq("ar_first", 0, 8'h00);
      rd("ar_r3", 2'd3, 8'h08);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Multi-cycle control unit that sits on the far side of the 8-bit ALU: it fetches 16-bit instructions from an external program memory, holds a 4×8 register file and a zero flag, and drives the ALU's `a`/`b`/`op` inputs. It consumes the ALU's `y`/`zero` outputs to write results back, and to resolve conditional jumps. Together with the combinational ALU and a program ROM it forms the datapath/control pair of the practice processor.

## Interface
- `PC_W`, default 8: program counter and instruction address width; the address space is 2^PC_W words.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Low forces the reset state immediately; release is synchronous to `clk`.
- `start` in 1: launches execution from IDLE or HALT. Ignored while `busy`=1.
- `instr_addr` out PC_W: fetch address, equal to the current PC.
- `instr_req` out 1: fetch request, high for the whole FETCH state.
- `instr_ack` in 1: memory acknowledge. `instr_data` is valid in the same cycle.
- `instr_data` in 16: instruction word.
- `alu_a` out 8: always `r[IR[8:7]]`.
- `alu_b` out 8: always `r[IR[6:5]]`.
- `alu_op` out 3: always `IR[13:11]`.
- `alu_y` in 8: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `busy` out 1: high in FETCH and EXEC.
- `halted` out 1: high in HALT.
- `err` out 1: fetch-timeout error (see Configuration).
- `dbg_sel` in 2: register-file debug read select.
- `dbg_data` out 8: `r[dbg_sel]`, combinational.

## Operation
Instruction encoding is selected by `IR[15:14]`:
- `00` ALU: fields `op`=[13:11], `rd`=[10:9], `ra`=[8:7], `rb`=[6:5]. Sets `r[rd] <= alu_y` and `Z <= alu_zero`.
- `01` LDI: fields `rd`=[13:12], `imm`=[7:0]. Sets `r[rd] <= imm`. Z is unchanged.
- `10` JMP: fields `cond`=[13], `target`=[PC_W-1:0]. If `cond`=0, or `cond`=1 and Z=1, then `PC <= target`. Otherwise the PC stays at the already-incremented value.
- `11` HALT: go to the HALT state. PC keeps the incremented value.
- Unused bits are ignored.

State machine (encoded states: IDLE, FETCH, EXEC, HALT):
- IDLE: on `start`=1, go to FETCH with PC=0.
- FETCH: `instr_req`=1. On a cycle where `instr_ack`=1, `IR <= instr_data`, `PC <= PC+1` (wraps modulo 2^PC_W), and go to EXEC.
- EXEC: one cycle. Performs the instruction above. Go to FETCH, or to HALT for opcode `11`.
- HALT: on `start`=1, clear `err`, set PC=0, go to FETCH. The register file and Z are retained.

Rules:
- The ALU is purely combinational. `alu_a`, `alu_b` and `alu_op` are stable for the full EXEC cycle, and `alu_y` is sampled at the end of that cycle.
- Arithmetic is modulo 256 and done by the ALU. This block only routes values.
- When `rd` equals `ra` or `rb`, the old operand value is used and the write takes effect at the clock edge.
- `instr_ack` is ignored outside FETCH.
- Reset values: PC=0; IR=0, so `alu_op`=000, `alu_a`=`alu_b`=`r0`=0; all registers 0; Z=0; state IDLE; `instr_req`=0, `busy`=0, `halted`=0, `err`=0.
- Reset asserted mid-instruction aborts it with no partial write.

## Timing
- Instruction latency is (1 + ack wait) fetch cycles + 1 EXEC cycle. With a zero-wait memory, each instruction takes 2 cycles.
- `start` is sampled once. Execution reaches FETCH in the cycle after `start`.
- A taken JMP fetches from `target` in the next FETCH cycle.
- `busy` falls in the same cycle that `halted` rises.

## Configuration
- `ALU_CTRL_WATCHDOG_EN` defined:
  - A 4-bit counter runs while in FETCH and is cleared on entry to FETCH.
  - If 15 consecutive FETCH cycles pass without `instr_ack`, the block sets `err`=1 and enters HALT.
  - `err` stays set until reset or the next `start`.
- `ALU_CTRL_WATCHDOG_EN` undefined: no counter, `err` is tied to 0, and FETCH waits indefinitely.

## Test plan
- Program `LDI r1,0x05; LDI r2,0x03; ALU op=010 rd=r3 ra=r1 rb=r2; HALT` with a zero-wait ROM:
  - `r3`=0x08, Z=0.
  - `halted` rises 8 cycles after `start`.
  - `instr_addr` sequence is 0,1,2,3.
- `LDI r1,0x07; ALU op=011 rd=r0 ra=r1 rb=r1; JMP cond=1 target=0x10`:
  - `r0`=0x00, Z=1, and the next fetch address is 0x10.
  - Repeat with the operand changed to r1 minus r2 (nonzero): the next fetch address is 3.
- `LDI r1,0xFF; LDI r2,0x01; ADD` → `r`=0x00, Z=1 (wrap). A following LDI leaves Z=1.
- PC at 2^PC_W−1 holding a non-jump instruction → the next fetch address is 0.
- ROM delays `instr_ack` by 3 cycles → `instr_req` held 4 cycles and the result is correct. With `ALU_CTRL_WATCHDOG_EN` defined and ack withheld: `err`=1 and `halted`=1 after 15 FETCH cycles.
- `reset` pulsed low during EXEC of an ALU write:
  - The destination register is unchanged (reads 0).
  - All outputs are at reset values during reset.
  - `start` after release runs from address 0.
